// File: rtl/serial_deser_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_deser_if
// Description : Bundle of serial-input, strobe/start and word-output signals
//               exchanged between a serial deserialiser and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_deser_if #(
  parameter int WIDTH = 8
);
  logic             sin;
  logic             sin_en;
  logic             start;
  logic             rdy;
  logic [WIDTH-1:0] dout;
  logic             dvalid;
  logic             busy;
  logic             ovf;
  logic [5:0]       bitcnt;

  // Environment side: drives the serial stream and the ready signal.
  modport master (
    output sin, sin_en, start, rdy,
    input  dout, dvalid, busy, ovf, bitcnt
  );

  // Deserialiser side.
  modport slave (
    input  sin, sin_en, start, rdy,
    output dout, dvalid, busy, ovf, bitcnt
  );
endinterface
`default_nettype wire

// File: rtl/serial_deser.sv
`default_nettype none
// ============================================================================
// Module      : serial_deser
// Description : MSB-first serial-to-parallel converter. A start pulse opens
//               a frame; WIDTH strobed bits form one word, which is presented
//               with a valid/ready handshake. A word completing while the
//               previous one is still unaccepted is dropped and flags a
//               sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_deser #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rstn,
  serial_deser_if.slave  bus
);

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_SHIFT = 1'b1;
  localparam logic [5:0] c_LAST     = 6'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_dout;
  logic [5:0]       r_bitcnt;
  logic             r_dvalid;
  logic             r_ovf;

  logic             w_in_shift;
  logic             w_strobe;
  logic             w_complete;
  logic             w_xfer;
  logic             w_busy;
  logic [WIDTH-1:0] w_word;

  // A start pulse always wins over a strobe in the same cycle, so a strobe
  // only counts in SHIFT without start.
  assign w_in_shift = (r_state == c_ST_SHIFT);
  assign w_strobe   = w_in_shift && !bus.start && bus.sin_en;
  assign w_complete = w_strobe && (r_bitcnt == c_LAST);
  assign w_word     = {r_sreg[WIDTH-2:0], bus.sin};
  assign w_xfer     = r_dvalid && bus.rdy;

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: start opens or restarts a frame, the last bit closes it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = c_ST_SHIFT;
        end
      end
      c_ST_SHIFT: begin
        if (bus.start) begin
          w_state_nxt = c_ST_SHIFT;
        end else if (w_complete) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FSM outputs: busy is decoded straight from the state register.
  always_comb begin
    w_busy = 1'b0;
    if (r_state == c_ST_SHIFT) begin
      w_busy = 1'b1;
    end
  end

  // Shift register and bit counter; start clears both in either state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sreg   <= '0;
      r_bitcnt <= '0;
    end else if (bus.start) begin
      r_sreg   <= '0;
      r_bitcnt <= '0;
    end else if (w_strobe) begin
      r_sreg   <= w_word;
      r_bitcnt <= w_complete ? 6'd0 : r_bitcnt + 6'd1;
    end
  end

  // Output word register: load when the slot is free or being emptied this
  // cycle, otherwise drop the word and latch the overrun flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_complete) begin
      if (!r_dvalid || bus.rdy) begin
        r_dout   <= w_word;
        r_dvalid <= 1'b1;
      end else begin
        r_ovf    <= 1'b1;
      end
    end else if (w_xfer) begin
      r_dvalid <= 1'b0;
    end
  end

  assign bus.dout   = r_dout;
  assign bus.dvalid = r_dvalid;
  assign bus.busy   = w_busy;
  assign bus.ovf    = r_ovf;
  assign bus.bitcnt = r_bitcnt;

endmodule
`default_nettype wire

// File: tb/tb_serial_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_deser
// Description : Scoreboard bench for serial_deser. The driver keeps a model of
//               the frame as a list of received bits and pushes each word
//               that should reach dout into a queue; a negedge monitor
//               compares DUT outputs against the model and pops on transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_deser;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rstn;

  serial_deser_if #(.WIDTH(WIDTH)) bus ();

  serial_deser #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (post-edge values).
  bit               m_busy  = 1'b0;
  bit               m_valid = 1'b0;
  bit               m_ovf   = 1'b0;
  bit               bits[$];
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, let the edge happen, then advance the model.
  task automatic step(input bit rn, input bit st, input bit en, input bit s, input bit r);
    logic [WIDTH-1:0] word;
    bit               done;
    bit               xfer;
    rstn       = rn;
    bus.start  = st;
    bus.sin_en = en;
    bus.sin    = s;
    bus.rdy    = r;
    @(posedge clk);
    if (!rn) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      bits.delete();
      exp_q.delete();
    end else begin
      xfer = m_valid && r;
      done = 1'b0;
      word = '0;
      if (st) begin
        m_busy = 1'b1;
        bits.delete();
      end else if (m_busy && en) begin
        bits.push_back(s);
        if (bits.size() == WIDTH) begin
          foreach (bits[i]) word = {word[WIDTH-2:0], bits[i]};
          bits.delete();
          m_busy = 1'b0;
          done   = 1'b1;
        end
      end
      if (done) begin
        if (!m_valid || r) begin
          m_valid = 1'b1;
          exp_q.push_back(word);
        end else begin
          m_ovf = 1'b1;
        end
      end else if (xfer) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input bit r);
    step(1'b1, 1'b0, 1'b0, 1'b0, r);
  endtask

  // Start pulse then nbits strobes of w, MSB first; rdy_last applies to the
  // final strobe cycle, rdy_rest to the others.
  task automatic send_frame(input logic [7:0] w, input int nbits, input bit rdy_rest, input bit rdy_last);
    logic [7:0] wv;
    wv = w;
    step(1'b1, 1'b1, 1'b0, 1'b0, rdy_rest);
    for (int i = 0; i < nbits; i++) begin
      step(1'b1, 1'b0, 1'b1, wv[7-i], (i == nbits - 1) ? rdy_last : rdy_rest);
    end
  endtask

  // Monitor: compare against the model between edges; a transfer pops.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy",   bus.busy,   m_busy);
      chk("dvalid", bus.dvalid, m_valid);
      chk("ovf",    bus.ovf,    m_ovf);
      chk("bitcnt", bus.bitcnt, bits.size());
      if (bus.dvalid) begin
        if (exp_q.size() == 0) begin
          chk("dvalid_unexpected", bus.dvalid, 1'b0);
        end else begin
          chk("dout", bus.dout, exp_q[0]);
          if (bus.rdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; bus.start = 1'b0; bus.sin_en = 1'b0; bus.sin = 1'b0; bus.rdy = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_dout", bus.dout, 8'h00);
    chk("reset_dvalid", bus.dvalid, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);

    // Basic frame 0x84 with rdy high.
    send_frame(8'h84, 8, 1'b1, 1'b1);
    chk("f84_dout", bus.dout, 8'h84);
    chk("f84_dvalid", bus.dvalid, 1'b1);
    chk("f84_busy", bus.busy, 1'b0);
    idle(1'b1);
    chk("f84_cleared", bus.dvalid, 1'b0);

    // Restart mid-frame after 5 bits, then 0xA5.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("restart_cnt0", bus.bitcnt, 6'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("restart_cnt", bus.bitcnt, 6'(i + 1));
    end
    send_frame(8'hA5, 8, 1'b1, 1'b1);
    chk("fA5_dout", bus.dout, 8'hA5);
    idle(1'b1);

    // Completion coinciding with a transfer: 0x01 held, 0x02 replaces it.
    send_frame(8'h01, 8, 1'b0, 1'b0);
    send_frame(8'h02, 8, 1'b0, 1'b1);
    chk("coinc_dout", bus.dout, 8'h02);
    chk("coinc_dvalid", bus.dvalid, 1'b1);
    chk("coinc_ovf", bus.ovf, 1'b0);
    idle(1'b1);

    // Overrun: 0x09 held, 0xFF dropped.
    send_frame(8'h09, 8, 1'b0, 1'b0);
    send_frame(8'hFF, 8, 1'b0, 1'b0);
    chk("ovr_dout", bus.dout, 8'h09);
    chk("ovr_dvalid", bus.dvalid, 1'b1);
    chk("ovr_ovf", bus.ovf, 1'b1);
    idle(1'b1);
    chk("ovr_cleared", bus.dvalid, 1'b0);
    chk("ovr_sticky", bus.ovf, 1'b1);

    // Reset at bitcnt 4 while a word is pending, then a clean 0x3C.
    send_frame(8'h55, 8, 1'b0, 1'b0);
    send_frame(8'h0F, 4, 1'b0, 1'b0);
    chk("mid_cnt4", bus.bitcnt, 6'd4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_dvalid", bus.dvalid, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    chk("rst_bitcnt", bus.bitcnt, 6'd0);
    chk("rst_busy", bus.busy, 1'b0);
    send_frame(8'h3C, 8, 1'b1, 1'b1);
    chk("f3C_dout", bus.dout, 8'h3C);
    idle(1'b1);

    // sin_en toggling in IDLE is ignored.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, i[0], 1'b1, 1'b1);
    end
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_bitcnt", bus.bitcnt, 6'd0);

    // Randomised traffic with gaps, restarts, back-pressure and resets.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0));
    end

    // Drain any pending word.
    for (int i = 0; i < 4; i++) idle(1'b1);
    @(negedge clk);
    chk("drained", bus.dvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
